// File: rtl/i2c_slave.sv
// Byte-oriented I2C target clocked by PCLK: oversampled SCL/SDA, START/STOP detection,
// 7-bit address match, write bytes pushed to an RX FIFO, read bytes popped from a TX FIFO.
module i2c_slave #(
   parameter logic [6:0] SLV_ADDR    = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       enable,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_o,
   input  logic [7:0] tx_data,
   input  logic       tx_empty,
   output logic       tx_rd,
   output logic [7:0] rx_data,
   input  logic       rx_full,
   output logic       rx_wr,
   output logic       busy,
   output logic       stop_det
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK
   } state_e;

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_dly_q, scl_dly_d;
   logic                   sda_dly_q, sda_dly_d;

   state_e     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       done_q, done_d;
   logic       rw_q, rw_d;
   logic       nack_q, nack_d;
   logic       sda_o_q, sda_o_d;
   logic       tx_rd_q, tx_rd_d;
   logic       rx_wr_q, rx_wr_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       stop_det_q, stop_det_d;

   logic scl_s, sda_s;
   logic scl_rise, scl_fall, start_ev, stop_ev;

   assign scl_s    = scl_sync_q[SYNC_STAGES-1];
   assign sda_s    = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_dly_q;
   assign scl_fall = ~scl_s & scl_dly_q;
   assign start_ev = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
   assign stop_ev  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_dly_d  = scl_s;
      sda_dly_d  = sda_s;
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      done_d     = done_q;
      rw_d       = rw_q;
      nack_d     = nack_q;
      sda_o_d    = sda_o_q;
      rx_data_d  = rx_data_q;
      tx_rd_d    = 1'b0;
      rx_wr_d    = 1'b0;
      stop_det_d = 1'b0;

      // Bus conditions override any SCL edge seen in the same cycle.
      if (stop_ev) begin
         state_d    = ST_IDLE;
         sda_o_d    = 1'b1;
         stop_det_d = 1'b1;
         done_d     = 1'b0;
         nack_d     = 1'b0;
      end else if (start_ev) begin
         state_d   = ST_ADDR;
         bit_cnt_d = 3'd0;
         sda_o_d   = 1'b1;
         done_d    = 1'b0;
         nack_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: sda_o_d = 1'b1;
            ST_ADDR, ST_WR_DATA: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) done_d = 1'b1;
               end else if (scl_fall && done_q) begin
                  done_d = 1'b0;
                  if (state_q == ST_ADDR) begin
                     rw_d = shift_q[0];
                     if ((shift_q[7:1] != SLV_ADDR) || !enable || (shift_q[0] && tx_empty)) begin
                        state_d = ST_IDLE;
                        sda_o_d = 1'b1;
                     end else begin
                        state_d = ST_ADDR_ACK;
                        sda_o_d = 1'b0;
                     end
                  end else begin
                     state_d = ST_WR_ACK;
                     if (!rx_full) begin
                        rx_wr_d   = 1'b1;
                        rx_data_d = shift_q;
                        sda_o_d   = 1'b0;
                     end else begin
                        sda_o_d = 1'b1;
                        nack_d  = 1'b1;
                     end
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_d = 3'd0;
                  done_d    = 1'b0;
                  if (rw_q) begin
                     tx_rd_d = 1'b1;
                     shift_d = tx_data;
                     sda_o_d = tx_data[7];
                     state_d = ST_RD_DATA;
                  end else begin
                     sda_o_d = 1'b1;
                     state_d = ST_WR_DATA;
                  end
               end
            end
            ST_WR_ACK: begin
               if (scl_fall) begin
                  sda_o_d   = 1'b1;
                  bit_cnt_d = 3'd0;
                  done_d    = 1'b0;
                  if (nack_q) begin
                     state_d = ST_IDLE;
                     nack_d  = 1'b0;
                  end else begin
                     state_d = ST_WR_DATA;
                  end
               end
            end
            ST_RD_DATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) done_d = 1'b1;
               end else if (scl_fall) begin
                  if (done_q) begin
                     done_d  = 1'b0;
                     sda_o_d = 1'b1;
                     state_d = ST_RD_ACK;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b0};
                     sda_o_d = shift_q[6];
                  end
               end
            end
            ST_RD_ACK: begin
               if (scl_rise) begin
                  if (sda_s) begin
                     state_d = ST_IDLE;
                     sda_o_d = 1'b1;
                  end else begin
                     done_d = 1'b1;
                  end
               end else if (scl_fall && done_q) begin
                  done_d    = 1'b0;
                  bit_cnt_d = 3'd0;
                  state_d   = ST_RD_DATA;
                  if (!tx_empty) begin
                     tx_rd_d = 1'b1;
                     shift_d = tx_data;
                     sda_o_d = tx_data[7];
                  end else begin
                     // Underrun: send all ones without popping.
                     shift_d = 8'hFF;
                     sda_o_d = 1'b1;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               sda_o_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_dly_q  <= 1'b1;
         sda_dly_q  <= 1'b1;
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         done_q     <= 1'b0;
         rw_q       <= 1'b0;
         nack_q     <= 1'b0;
         sda_o_q    <= 1'b1;
         tx_rd_q    <= 1'b0;
         rx_wr_q    <= 1'b0;
         rx_data_q  <= 8'h00;
         stop_det_q <= 1'b0;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_dly_q  <= scl_dly_d;
         sda_dly_q  <= sda_dly_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         done_q     <= done_d;
         rw_q       <= rw_d;
         nack_q     <= nack_d;
         sda_o_q    <= sda_o_d;
         tx_rd_q    <= tx_rd_d;
         rx_wr_q    <= rx_wr_d;
         rx_data_q  <= rx_data_d;
         stop_det_q <= stop_det_d;
      end
   end

   assign sda_o    = sda_o_q;
   assign tx_rd    = tx_rd_q;
   assign rx_wr    = rx_wr_q;
   assign rx_data  = rx_data_q;
   assign stop_det = stop_det_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-level bus master model, TX FIFO model and RX/read scoreboards.
module tb_i2c_slave;

   logic       PCLK    = 1'b0;
   logic       PRESETn = 1'b0;
   logic       enable  = 1'b1;
   logic       scl_m   = 1'b1;
   logic       sda_m   = 1'b1;
   logic       rx_full = 1'b0;
   logic       tx_empty = 1'b1;
   logic [7:0] tx_data  = 8'h00;
   logic       sda_o, tx_rd, rx_wr, busy, stop_det;
   logic [7:0] rx_data;
   logic       sda_bus;

   int n_checks = 0;
   int n_errors = 0;
   int n_rx = 0, n_tx = 0, n_stop = 0, n_sda_low = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rd_exp_q[$];
   logic [7:0] tx_q[$];

   assign sda_bus = sda_m & sda_o;

   i2c_slave #(.SLV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .PCLK     (PCLK),
      .PRESETn  (PRESETn),
      .enable   (enable),
      .scl_i    (scl_m),
      .sda_i    (sda_bus),
      .sda_o    (sda_o),
      .tx_data  (tx_data),
      .tx_empty (tx_empty),
      .tx_rd    (tx_rd),
      .rx_data  (rx_data),
      .rx_full  (rx_full),
      .rx_wr    (rx_wr),
      .busy     (busy),
      .stop_det (stop_det)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   task automatic monitor();
      forever begin
         @(negedge PCLK);
         if (PRESETn) begin
            if (rx_wr || tx_rd) check("rd_wr_exclusive", {31'd0, rx_wr & tx_rd}, 32'd0);
            if (rx_wr) begin
               n_rx++;
               check("rx_expected", {31'd0, exp_q.size() > 0}, 32'd1);
               if (exp_q.size() > 0) check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
            if (tx_rd) begin
               n_tx++;
               if (tx_q.size() > 0) void'(tx_q.pop_front());
            end
            if (stop_det) n_stop++;
            if (!sda_o) n_sda_low++;
         end
         tx_empty = (tx_q.size() == 0);
         tx_data  = tx_empty ? 8'h00 : tx_q[0];
      end
   endtask

   task automatic bit_cycle(input logic b, output logic s);
      wait_clk(5);
      sda_m = b;
      wait_clk(5);
      scl_m = 1'b1;
      wait_clk(4);
      s = sda_bus;
      wait_clk(4);
      scl_m = 1'b0;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      wait_clk(6);
      scl_m = 1'b1;
      wait_clk(4);
      sda_m = 1'b0;
      wait_clk(4);
      scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_clk(2);
      sda_m = 1'b0;
      wait_clk(6);
      scl_m = 1'b1;
      wait_clk(4);
      sda_m = 1'b1;
      wait_clk(8);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
      bit_cycle(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(output logic [7:0] b, input logic m_ack);
      logic s;
      b = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         bit_cycle(1'b1, s);
         b[i] = s;
      end
      bit_cycle(~m_ack, s);
   endtask

   initial begin
      logic       ack;
      logic [7:0] rb;
      logic [7:0] addr;
      logic       s;
      int rx0, tx0, st0, low0;

      fork
         monitor();
      join_none

      // Reset values
      wait_clk(3);
      check("rst_sda_o", {31'd0, sda_o}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_tx_rd", {31'd0, tx_rd}, 32'd0);
      check("rst_rx_wr", {31'd0, rx_wr}, 32'd0);
      check("rst_rx_data", {24'd0, rx_data}, 32'd0);
      check("rst_stop_det", {31'd0, stop_det}, 32'd0);
      PRESETn = 1'b1;
      wait_clk(4);

      // Write two bytes
      rx0 = n_rx; st0 = n_stop;
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'h81);
      i2c_start();
      write_byte(8'hA0, ack); check("wr_addr_ack", {31'd0, ack}, 32'd1);
      write_byte(8'h3C, ack); check("wr_b0_ack", {31'd0, ack}, 32'd1);
      write_byte(8'h81, ack); check("wr_b1_ack", {31'd0, ack}, 32'd1);
      i2c_stop();
      check("wr_rx_count", n_rx - rx0, 32'd2);
      check("wr_stop_count", n_stop - st0, 32'd1);
      check("wr_busy_after_stop", {31'd0, busy}, 32'd0);
      check("wr_rx_queue_left", exp_q.size(), 32'd0);

      // Read two bytes, ACK then NACK
      tx0 = n_tx;
      tx_q.push_back(8'h5A); rd_exp_q.push_back(8'h5A);
      tx_q.push_back(8'hC3); rd_exp_q.push_back(8'hC3);
      wait_clk(2);
      i2c_start();
      write_byte(8'hA1, ack); check("rd_addr_ack", {31'd0, ack}, 32'd1);
      read_byte(rb, 1'b1); check("rd_byte0", {24'd0, rb}, {24'd0, rd_exp_q.pop_front()});
      read_byte(rb, 1'b0); check("rd_byte1", {24'd0, rb}, {24'd0, rd_exp_q.pop_front()});
      wait_clk(6);
      check("rd_busy_after_nack", {31'd0, busy}, 32'd0);
      i2c_stop();
      check("rd_tx_count", n_tx - tx0, 32'd2);
      check("rd_tx_fifo_left", tx_q.size(), 32'd0);

      // Address mismatch, then matching address with enable low
      for (int k = 0; k < 2; k++) begin
         rx0 = n_rx; tx0 = n_tx; low0 = n_sda_low;
         enable = (k == 0);
         addr   = (k == 0) ? 8'hA2 : 8'hA0;
         wait_clk(2);
         i2c_start();
         write_byte(addr, ack); check("noaddr_ack", {31'd0, ack}, 32'd0);
         wait_clk(2);
         check("noaddr_busy", {31'd0, busy}, 32'd0);
         i2c_stop();
         check("noaddr_sda_low", n_sda_low - low0, 32'd0);
         check("noaddr_rx", n_rx - rx0, 32'd0);
         check("noaddr_tx", n_tx - tx0, 32'd0);
      end
      enable = 1'b1;

      // RX FIFO full on the second byte
      rx0 = n_rx;
      exp_q.push_back(8'h11);
      i2c_start();
      write_byte(8'hA0, ack); check("full_addr_ack", {31'd0, ack}, 32'd1);
      write_byte(8'h11, ack); check("full_b0_ack", {31'd0, ack}, 32'd1);
      rx_full = 1'b1;
      write_byte(8'h22, ack); check("full_b1_nack", {31'd0, ack}, 32'd0);
      wait_clk(6);
      check("full_busy", {31'd0, busy}, 32'd0);
      rx_full = 1'b0;
      i2c_stop();
      check("full_rx_count", n_rx - rx0, 32'd1);

      // Write then repeated START into a read
      rx0 = n_rx; tx0 = n_tx;
      exp_q.push_back(8'h10);
      tx_q.push_back(8'h77); rd_exp_q.push_back(8'h77);
      wait_clk(2);
      i2c_start();
      write_byte(8'hA0, ack); check("rs_wr_addr_ack", {31'd0, ack}, 32'd1);
      write_byte(8'h10, ack); check("rs_wr_ack", {31'd0, ack}, 32'd1);
      i2c_start();
      write_byte(8'hA1, ack); check("rs_rd_addr_ack", {31'd0, ack}, 32'd1);
      read_byte(rb, 1'b0); check("rs_rd_byte", {24'd0, rb}, {24'd0, rd_exp_q.pop_front()});
      i2c_stop();
      check("rs_rx_count", n_rx - rx0, 32'd1);
      check("rs_tx_count", n_tx - tx0, 32'd1);

      // Reset while the address ACK is being driven
      addr = 8'hA0;
      i2c_start();
      for (int i = 7; i >= 0; i--) bit_cycle(addr[i], s);
      wait_clk(6);
      check("rst_mid_pre_sda", {31'd0, sda_o}, 32'd0);
      #2 PRESETn = 1'b0;
      #1;
      check("rst_mid_sda", {31'd0, sda_o}, 32'd1);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      wait_clk(1);
      scl_m = 1'b1;
      wait_clk(2);
      sda_m = 1'b1;
      wait_clk(4);
      PRESETn = 1'b1;
      wait_clk(4);
      rx0 = n_rx;
      exp_q.push_back(8'h55);
      i2c_start();
      write_byte(8'hA0, ack); check("post_rst_addr_ack", {31'd0, ack}, 32'd1);
      write_byte(8'h55, ack); check("post_rst_ack", {31'd0, ack}, 32'd1);
      i2c_stop();
      check("post_rst_rx_count", n_rx - rx0, 32'd1);
      check("final_rx_queue", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- Byte-oriented I2C target (slave) clocked by the system PCLK; the responder end of the bus driven by our I2C master.
- Oversamples SCL/SDA and detects START, repeated START and STOP.
- Matches a 7-bit address; receives write bytes into an RX FIFO and transmits read bytes from a TX FIFO, with ACK/NACK handling.
- No clock stretching: SCL is input-only.

Parameters:
- SLV_ADDR, 7'h50, own 7-bit bus address.
- SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i (min 2).

Ports:
- PCLK  input  1  system clock; must be >= 8x the SCL frequency.
- PRESETn  input  1  asynchronous, active-low reset.
- enable  input  1  1 = respond to address; 0 = never ACK.
- scl_i  input  1  SCL pad input.
- sda_i  input  1  SDA pad input.
- sda_o  output  1  open-drain control: 0 pulls SDA low, 1 releases it.
- tx_data  input  8  head of TX FIFO (first-word-fall-through).
- tx_empty  input  1  TX FIFO empty.
- tx_rd  output  1  one-PCLK pop pulse to TX FIFO.
- rx_data  output  8  received byte; valid while rx_wr = 1.
- rx_full  input  1  RX FIFO full.
- rx_wr  output  1  one-PCLK push pulse to RX FIFO.
- busy  output  1  1 while state != IDLE.
- stop_det  output  1  one-PCLK pulse on every detected STOP.

Behaviour:
- Reset (async, immediate): sda_o=1, tx_rd=0, rx_wr=0, rx_data=8'h00, busy=0, stop_det=0, state=IDLE, bit_cnt=0.
- Input path: SYNC_STAGES flops per line, then one delay flop for edge detection. Bus-to-event latency is SYNC_STAGES+1 PCLK.
- Events:
  - scl_rise / scl_fall: edges of synced SCL.
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - START/STOP take priority over an SCL edge detected in the same cycle.
- Timing rule: SDA is sampled on scl_rise; sda_o changes only on scl_fall, registered (one PCLK after the event).
- Shifting: MSB first; bit_cnt is 3 bits and counts 0..7.
- States:
  - IDLE: sda_o=1. START -> ADDR, bit_cnt=0.
  - ADDR: shift 8 bits on scl_rise. On the scl_fall after bit 8:
    - Address != SLV_ADDR or enable=0 -> IDLE, sda stays released.
    - Match and R/W=0 -> ADDR_ACK, sda_o=0.
    - Match, R/W=1, tx_empty=0 -> ADDR_ACK, sda_o=0.
    - Match, R/W=1, tx_empty=1 -> NACK: sda_o=1, go to IDLE.
  - ADDR_ACK: hold sda_o=0. On the next scl_fall:
    - Write: release sda, go to WR_DATA.
    - Read: pulse tx_rd, load the shift register from tx_data in that same cycle, drive bit7, go to RD_DATA.
  - WR_DATA: shift 8 bits. On the scl_fall after bit 8:
    - rx_full=0: rx_wr pulse with rx_data=byte, sda_o=0 (ACK).
    - rx_full=1: byte dropped, sda_o=1 (NACK), nack flag set.
    - Either way -> WR_ACK.
  - WR_ACK: on the next scl_fall release sda; go to WR_DATA, or IDLE if nack flag set.
  - RD_DATA: drive the next bit on each scl_fall. On the scl_fall after bit 8 is clocked, release sda and go to RD_ACK.
  - RD_ACK: sample SDA on scl_rise.
    - Master ACK (0), on the next scl_fall:
      - tx_empty=0: pulse tx_rd, load the next byte, drive bit7, go to RD_DATA.
      - tx_empty=1: load 8'hFF with no tx_rd (underrun), go to RD_DATA.
    - Master NACK (1): go to IDLE, sda released.
- START in any state: go to ADDR, bit_cnt=0, sda_o=1, nack flag cleared.
- STOP in any state: go to IDLE, sda_o=1, stop_det pulse.
- tx_rd and rx_wr are never asserted in the same cycle; each transferred byte produces exactly one pulse.
- Reset mid-transfer: the bus is released at once and no partial byte is pushed.

Test Plan:
- Write: START, 0xA0, 0x3C, 0x81, STOP -> ACK (sda_o=0) on the 9th clock of each byte; exactly two rx_wr pulses with rx_data 0x3C then 0x81; stop_det pulse; busy=0 within 3 PCLK of STOP.
- Read: TX FIFO holds 0x5A, 0xC3; START, 0xA1; master ACKs byte 1 and NACKs byte 2, then STOP -> SDA carries 01011010 then 11000011; exactly 2 tx_rd pulses; state returns to IDLE.
- Address 0xA2 (mismatch), and separately 0xA0 with enable=0 -> sda_o=1 throughout; no rx_wr or tx_rd; busy=0 after the 9th SCL fall.
- Write 0xA0, 0x11, then 0x22 with rx_full=1 -> ACK on 0x11 with one rx_wr; NACK on 0x22 with no rx_wr; returns to IDLE.
- Write 0xA0, 0x10, repeated START, 0xA1 read with TX FIFO = 0x77 -> one rx_wr (0x10); ACK on the repeated address; 0x77 transmitted with one tx_rd.
- Assert PRESETn low while sda_o=0 during ADDR_ACK -> sda_o=1 and busy=0 immediately, with no PCLK edge needed; a following write 0xA0, 0x55 behaves normally.
